// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multi-cycle RV32I controller: FSM states,
// opcodes, ALU operation codes and datapath select encodings.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9
    } state_t;

    // Operation class handed to the ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    // Unknown branch funct3 values fall back to beq behaviour.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic zflag,
                                          input logic sflag);
        case (funct3)
            F3_BEQ:  return zflag;
            F3_BNE:  return ~zflag;
            F3_BLT:  return sflag;
            default: return zflag;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the operation class plus instruction fields onto the ALU control code;
// shared by the address/increment adds, the branch compare and execute states.
module alu_decoder
    import riscv_mc_pkg::*;
(
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  aluop_t     aluop,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op5 set) can request sub; addi ignores bit 30.
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback, driving every datapath select and strobe.
module multicycle_controller
    import riscv_mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        ZFlag,
    input  logic        SFlag,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        instr_done
);

    state_t     state;
    state_t     next_state;
    aluop_t     aluop;
    logic [2:0] alu_ctrl;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_mem;
    logic       is_store;
    logic       is_rtype;
    logic       is_itype;
    logic       is_branch;
    logic       unused_instr_bits;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign is_store  = (opcode == OP_STORE);
    assign is_mem    = (opcode == OP_LOAD) || is_store;
    assign is_rtype  = (opcode == OP_RTYPE);
    assign is_itype  = (opcode == OP_ITYPE);
    assign is_branch = (opcode == OP_BRANCH);

    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_FETCH:    next_state = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (is_mem)         next_state = ST_MEMADR;
                else if (is_rtype)  next_state = ST_EXECR;
                else if (is_itype)  next_state = ST_EXECI;
                else if (is_branch) next_state = ST_BRANCH;
                else                next_state = ST_FETCH;
            end
            ST_MEMADR:   next_state = is_store ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  next_state = mem_ready ? ST_MEMWB : ST_MEMREAD;
            ST_MEMWB:    next_state = ST_FETCH;
            ST_MEMWRITE: next_state = mem_ready ? ST_FETCH : ST_MEMWRITE;
            ST_EXECR:    next_state = ST_ALUWB;
            ST_EXECI:    next_state = ST_ALUWB;
            ST_ALUWB:    next_state = ST_FETCH;
            ST_BRANCH:   next_state = ST_FETCH;
            default:     next_state = ST_FETCH;
        endcase
    end

    always_comb begin
        aluop = ALUOP_ADD;
        case (state)
            ST_EXECR, ST_EXECI: aluop = ALUOP_FUNCT;
            ST_BRANCH:          aluop = ALUOP_SUB;
            default:            aluop = ALUOP_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .op5         (opcode[5]),
        .funct3      (funct3),
        .funct7b5    (instr[30]),
        .aluop       (aluop),
        .alu_control (alu_ctrl)
    );

    // Strobes depend on mem_ready/flags in the same cycle, so outputs stay
    // combinational; rst gates everything so no access escapes an abort.
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;
        instr_done = 1'b0;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    ALUSrcA    = SRCA_PC;
                    ALUSrcB    = SRCB_FOUR;
                    ResultSrc  = RES_ALURESULT;
                    ALUControl = alu_ctrl;
                    IRWrite    = mem_ready;
                    PCWrite    = mem_ready;
                end
                ST_DECODE: begin
                    ALUSrcA    = SRCA_OLDPC;
                    ALUSrcB    = SRCB_IMM;
                    ImmSrc     = IMM_B;
                    ALUControl = alu_ctrl;
                    instr_done = !(is_mem || is_rtype || is_itype || is_branch);
                end
                ST_MEMADR: begin
                    ALUSrcA    = SRCA_RS1;
                    ALUSrcB    = SRCB_IMM;
                    ImmSrc     = is_store ? IMM_S : IMM_I;
                    ALUControl = alu_ctrl;
                end
                ST_MEMREAD: begin
                    AdrSrc    = 1'b1;
                    ResultSrc = RES_ALUOUT;
                end
                ST_MEMWB: begin
                    ResultSrc  = RES_DATA;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                ST_MEMWRITE: begin
                    AdrSrc     = 1'b1;
                    ResultSrc  = RES_ALUOUT;
                    MemWrite   = 1'b1;
                    instr_done = mem_ready;
                end
                ST_EXECR: begin
                    ALUSrcA    = SRCA_RS1;
                    ALUSrcB    = SRCB_RS2;
                    ALUControl = alu_ctrl;
                end
                ST_EXECI: begin
                    ALUSrcA    = SRCA_RS1;
                    ALUSrcB    = SRCB_IMM;
                    ImmSrc     = IMM_I;
                    ALUControl = alu_ctrl;
                end
                ST_ALUWB: begin
                    ResultSrc  = RES_ALUOUT;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                ST_BRANCH: begin
                    ALUSrcA    = SRCA_RS1;
                    ALUSrcB    = SRCB_RS2;
                    ResultSrc  = RES_ALUOUT;
                    ALUControl = alu_ctrl;
                    PCWrite    = branch_taken(funct3, ZFlag, SFlag);
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: a per-instruction expected
// cycle trace is built from the instruction class rules and compared per cycle.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        ZFlag, SFlag, mem_ready;
    logic        PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, instr_done;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;
    logic [16:0] out_vec;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic        mr;
        logic        z;
        logic        s;
        logic [16:0] exp;
    } cyc_t;

    cyc_t tr[$];

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .ZFlag      (ZFlag),
        .SFlag      (SFlag),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    assign out_vec = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
                      ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_done};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] ov(input logic pcw, input logic adr, input logic irw,
                                       input logic mw, input logic rw, input logic [1:0] res,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] imm, input logic [2:0] alu,
                                       input logic done);
        return {pcw, adr, irw, mw, rw, res, sa, sb, imm, alu, done};
    endfunction

    function automatic logic [2:0] exp_alu(input logic [31:0] i);
        logic [2:0] f3;
        f3 = i[14:12];
        if (f3 == 3'd0) return (i[5] && i[30]) ? 3'b010 : 3'b000;
        if (f3 == 3'd2 || f3 == 3'd3) return 3'b000;
        return f3;
    endfunction

    task automatic push(input logic mr, input logic z, input logic s, input logic [16:0] e);
        cyc_t c;
        c.mr = mr; c.z = z; c.s = s; c.exp = e;
        tr.push_back(c);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Builds the expected trace; returns the cycle count from plain arithmetic.
    task automatic build(input logic [31:0] i, input int fw, input int mw,
                         input logic bz, input logic bs, output int len);
        logic [6:0] op;
        logic       taken;
        op = i[6:0];
        tr.delete();
        for (int k = 0; k < fw; k++) push(1'b0, rb(), rb(), ov(0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,3'd0,0));
        push(1'b1, rb(), rb(), ov(1,0,1,0,0,2'd2,2'd0,2'd2,2'd0,3'd0,0));
        push(rb(), rb(), rb(), ov(0,0,0,0,0,2'd0,2'd1,2'd1,2'd2,3'd0,
            !(op == 7'h03 || op == 7'h23 || op == 7'h33 || op == 7'h13 || op == 7'h63)));
        len = 2 + fw;
        if (op == 7'h03) begin
            push(rb(), rb(), rb(), ov(0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,3'd0,0));
            for (int k = 0; k < mw; k++) push(1'b0, rb(), rb(), ov(0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,0));
            push(1'b1, rb(), rb(), ov(0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,0));
            push(rb(), rb(), rb(), ov(0,0,0,0,1,2'd1,2'd0,2'd0,2'd0,3'd0,1));
            len += 3 + mw;
        end else if (op == 7'h23) begin
            push(rb(), rb(), rb(), ov(0,0,0,0,0,2'd0,2'd2,2'd1,2'd1,3'd0,0));
            for (int k = 0; k < mw; k++) push(1'b0, rb(), rb(), ov(0,1,0,1,0,2'd0,2'd0,2'd0,2'd0,3'd0,0));
            push(1'b1, rb(), rb(), ov(0,1,0,1,0,2'd0,2'd0,2'd0,2'd0,3'd0,1));
            len += 2 + mw;
        end else if (op == 7'h33 || op == 7'h13) begin
            push(rb(), rb(), rb(), ov(0,0,0,0,0,2'd0,2'd2,(op == 7'h13) ? 2'd1 : 2'd0,2'd0,exp_alu(i),0));
            push(rb(), rb(), rb(), ov(0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,3'd0,1));
            len += 2;
        end else if (op == 7'h63) begin
            case (i[14:12])
                3'd1:    taken = !bz;
                3'd4:    taken = bs;
                default: taken = bz;
            endcase
            push(rb(), bz, bs, ov(taken,0,0,0,0,2'd0,2'd2,2'd0,2'd0,3'd2,1));
            len += 1;
        end
    endtask

    task automatic reset_cycle(input string tag);
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1; ZFlag = rb(); SFlag = rb();
        #1;
        check(tag, {15'd0, out_vec}, 32'd0);
    endtask

    task automatic run(input logic [31:0] i, input int fw, input int mw,
                       input logic bz, input logic bs, input logic abort);
        int len, abort_at, dones, done_cyc;
        build(i, fw, mw, bz, bs, len);
        abort_at = abort ? $urandom_range(1, tr.size() - 1) : -1;
        dones = 0; done_cyc = 0;
        for (int k = 0; k < tr.size(); k++) begin
            if (k == abort_at) begin
                reset_cycle("rst_mid");
                return;
            end
            @(negedge clk);
            rst = 1'b0; instr = i;
            mem_ready = tr[k].mr; ZFlag = tr[k].z; SFlag = tr[k].s;
            #1;
            check($sformatf("outs_%h_c%0d", i, k), {15'd0, out_vec}, {15'd0, tr[k].exp});
            check("excl", {31'd0, (MemWrite && (IRWrite || PCWrite)) || (RegWrite && MemWrite)}, 32'd0);
            if (instr_done) begin
                dones++;
                done_cyc = k + 1;
            end
        end
        check($sformatf("len_%h", i), done_cyc, len);
        check($sformatf("once_%h", i), dones, 1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        logic [6:0]  op;
        i = $urandom;
        case ($urandom_range(0, 5))
            0: op = 7'h03;
            1: op = 7'h23;
            2: op = 7'h33;
            3: op = 7'h13;
            4: op = 7'h63;
            default: begin
                op = 7'($urandom);
                while (op == 7'h03 || op == 7'h23 || op == 7'h33 || op == 7'h13 || op == 7'h63)
                    op = 7'($urandom);
            end
        endcase
        i[6:0] = op;
        return i;
    endfunction

    initial begin
        rst = 1'b1; instr = 32'h0; mem_ready = 1'b1; ZFlag = 1'b0; SFlag = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            check("rst_hold", {15'd0, out_vec}, 32'd0);
        end

        run(32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0);
        run(32'h402081B3, 0, 0, 1'b0, 1'b0, 1'b0);
        run(32'h0FF0C093, 0, 0, 1'b0, 1'b0, 1'b0);
        run(32'h0000A103, 0, 3, 1'b0, 1'b0, 1'b0);
        run(32'h0020A023, 0, 2, 1'b0, 1'b0, 1'b0);
        run(32'h00208063, 0, 0, 1'b1, 1'b0, 1'b0);
        run(32'h00209063, 0, 0, 1'b1, 1'b0, 1'b0);
        run(32'h0020C063, 0, 0, 1'b0, 1'b1, 1'b0);
        run(32'h0000007F, 0, 0, 1'b0, 1'b0, 1'b0);
        run(32'h0000A103, 2, 0, 1'b0, 1'b0, 1'b1);
        run(32'h0020A023, 0, 3, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 300; n++) begin
            run(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3),
                rb(), rb(), $urandom_range(0, 9) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
